// File: rtl/sprite_pkg.sv
// Shared constants for the sprite controller: state encoding, sprite size,
// screen geometry and default motion tuning.
package sprite_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DEAD = 2'b10;

   localparam int SPRITE_W = 26;
   localparam int SPRITE_H = 32;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic        [10:0] SPRITE_X_DEF = 11'd100;
   localparam logic signed [11:0] FLOOR_Y_DEF  = 12'sd448;
   localparam logic signed [11:0] Y_START_DEF  = 12'sd200;
   localparam logic signed [11:0] GRAVITY_DEF  = 12'sd1;
   localparam logic signed [11:0] FLAP_V_DEF   = 12'sd8;
   localparam logic signed [11:0] V_MAX_DEF    = 12'sd10;

   function automatic logic [11:0] zext12(input logic [10:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/sprite_motion.sv
// Per-frame flap/gravity state machine owning the sprite's vertical position.
// sprite_y only moves on frame_tick so a visible frame never tears.
module sprite_motion
   import sprite_pkg::*;
#(
   parameter int                 SPR_H   = SPRITE_H,
   parameter logic signed [11:0] Y_START = Y_START_DEF,
   parameter logic signed [11:0] FLOOR_Y = FLOOR_Y_DEF,
   parameter logic signed [11:0] GRAVITY = GRAVITY_DEF,
   parameter logic signed [11:0] FLAP_V  = FLAP_V_DEF,
   parameter logic signed [11:0] V_MAX   = V_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_frame_tick,
   input  logic               i_flap,
   input  logic               i_hit,
   input  logic               i_restart,
   output logic signed [11:0] o_sprite_y,
   output logic [1:0]         o_state
);

   localparam logic signed [11:0] Y_LIMIT = FLOOR_Y - 12'(SPR_H);

   logic [1:0]         r_state;
   logic signed [11:0] r_y;
   logic signed [11:0] r_vel;
   logic               r_pend;

   logic signed [11:0] w_vel_next;
   logic signed [11:0] w_y_next;

   function automatic logic signed [11:0] sat_fall(input logic signed [11:0] v);
      logic signed [11:0] t;
      t = v + GRAVITY;
      return (t > V_MAX) ? V_MAX : t;
   endfunction

   // A flap seen anywhere in the frame, or on the tick itself, overrides gravity.
   assign w_vel_next = (r_pend || i_flap) ? -FLAP_V : sat_fall(r_vel);
   assign w_y_next   = r_y + w_vel_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_y     <= Y_START;
         r_vel   <= '0;
         r_pend  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_y    <= Y_START;
               r_pend <= 1'b0;
               if (i_flap) begin
                  r_state <= ST_RUN;
                  r_vel   <= -FLAP_V;
               end else begin
                  r_vel <= '0;
               end
            end
            ST_RUN: begin
               if (i_hit) begin
                  r_state <= ST_DEAD;
                  r_pend  <= 1'b0;
               end else if (i_frame_tick) begin
                  r_pend <= 1'b0;
                  if (w_y_next < 12'sd0) begin
                     r_y   <= '0;
                     r_vel <= '0;
                  end else if (w_y_next >= Y_LIMIT) begin
                     r_y     <= Y_LIMIT;
                     r_vel   <= '0;
                     r_state <= ST_DEAD;
                  end else begin
                     r_y   <= w_y_next;
                     r_vel <= w_vel_next;
                  end
               end else if (i_flap) begin
                  r_pend <= 1'b1;
               end
            end
            ST_DEAD: begin
               r_pend <= 1'b0;
               if (i_restart) begin
                  r_state <= ST_IDLE;
                  r_y     <= Y_START;
                  r_vel   <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_y     <= Y_START;
               r_vel   <= '0;
               r_pend  <= 1'b0;
            end
         endcase
      end
   end

   assign o_sprite_y = r_y;
   assign o_state    = r_state;

endmodule

// File: rtl/sprite_ctrl.sv
// Sprite ROM sequencer and compositor for the VGA pixel pipeline: maps screen
// coordinates into the sprite, aligns with the ROM's registered row, blends.
module sprite_ctrl
   import sprite_pkg::*;
#(
   parameter logic [10:0]        SPR_X   = SPRITE_X_DEF,
   parameter int                 SPR_W   = SPRITE_W,
   parameter int                 SPR_H   = SPRITE_H,
   parameter logic signed [11:0] Y_START = Y_START_DEF,
   parameter logic signed [11:0] FLOOR_Y = FLOOR_Y_DEF,
   parameter logic signed [11:0] GRAVITY = GRAVITY_DEF,
   parameter logic signed [11:0] FLAP_V  = FLAP_V_DEF,
   parameter logic signed [11:0] V_MAX   = V_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [10:0]        i_x,
   input  logic [10:0]        i_y,
   input  logic               frame_tick,
   input  logic               flap,
   input  logic               hit,
   input  logic               restart,
   input  logic [7:0]         bg_r,
   input  logic [7:0]         bg_g,
   input  logic [7:0]         bg_b,
   output logic [10:0]        spr_ix,
   output logic [10:0]        spr_iy,
   input  logic [7:0]         spr_r,
   input  logic [7:0]         spr_g,
   input  logic [7:0]         spr_b,
   input  logic               spr_mask,
   output logic [7:0]         o_r,
   output logic [7:0]         o_g,
   output logic [7:0]         o_b,
   output logic signed [11:0] sprite_y,
   output logic [1:0]         state,
   output logic               dead
);

   logic [11:0] w_ix_diff;
   logic [11:0] w_iy_diff;
   logic        w_active;
   logic        w_win;

   logic        r_vld_p0;
   logic        r_vld_p1;
   logic        r_win_p0;
   logic        r_win_p1;
   logic [10:0] r_ix_p0;
   logic [23:0] r_bg_p0;
   logic [23:0] r_bg_p1;

   sprite_motion #(
      .SPR_H   (SPR_H),
      .Y_START (Y_START),
      .FLOOR_Y (FLOOR_Y),
      .GRAVITY (GRAVITY),
      .FLAP_V  (FLAP_V),
      .V_MAX   (V_MAX)
   ) u_motion (
      .clk          (clk),
      .rst          (rst),
      .i_frame_tick (frame_tick),
      .i_flap       (flap),
      .i_hit        (hit),
      .i_restart    (restart),
      .o_sprite_y   (sprite_y),
      .o_state      (state)
   );

   assign dead = (state == ST_DEAD);

   // Differences wrap to large unsigned values when the pixel is left of / above the sprite.
   assign w_ix_diff = zext12(i_x) - zext12(SPR_X);
   assign w_iy_diff = zext12(i_y) - $unsigned(sprite_y);
   assign w_active  = (i_x < 11'(SCREEN_W)) && (i_y < 11'(SCREEN_H));
   assign w_win     = w_active && (w_ix_diff < 12'(SPR_W)) && (w_iy_diff < 12'(SPR_H));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_win_p0 <= 1'b0;
         r_win_p1 <= 1'b0;
         spr_iy   <= '0;
         spr_ix   <= '0;
         o_r      <= '0;
         o_g      <= '0;
         o_b      <= '0;
      end else begin
         // stage 0: window test, ROM row address
         r_vld_p0 <= 1'b1;
         r_win_p0 <= w_win;
         spr_iy   <= w_win ? w_iy_diff[10:0] : '0;
         // stage 1: ROM row latched, column select drives colour
         r_vld_p1 <= r_vld_p0;
         r_win_p1 <= r_win_p0;
         spr_ix   <= r_ix_p0;
         // stage 2: composite
         if (!r_vld_p1) begin
            {o_r, o_g, o_b} <= '0;
         end else if (r_win_p1 && spr_mask) begin
            {o_r, o_g, o_b} <= {spr_r, spr_g, spr_b};
         end else begin
            {o_r, o_g, o_b} <= r_bg_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      r_ix_p0 <= w_win ? w_ix_diff[10:0] : '0;
      r_bg_p0 <= {bg_r, bg_g, bg_b};
      r_bg_p1 <= r_bg_p0;
   end

endmodule

// File: tb/tb_sprite_ctrl.sv
// Self-checking bench for sprite_ctrl: pixel scoreboard with a ROM model and a
// behavioural model of the flap/gravity motion.
module tb_sprite_ctrl;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DEAD = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [10:0]        i_x, i_y;
   logic               frame_tick, flap, hit, restart;
   logic [7:0]         bg_r, bg_g, bg_b;
   logic [10:0]        spr_ix, spr_iy;
   logic [7:0]         spr_r, spr_g, spr_b;
   logic               spr_mask;
   logic [7:0]         o_r, o_g, o_b;
   logic signed [11:0] sprite_y;
   logic [1:0]         state;
   logic               dead;

   sprite_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_x        (i_x),
      .i_y        (i_y),
      .frame_tick (frame_tick),
      .flap       (flap),
      .hit        (hit),
      .restart    (restart),
      .bg_r       (bg_r),
      .bg_g       (bg_g),
      .bg_b       (bg_b),
      .spr_ix     (spr_ix),
      .spr_iy     (spr_iy),
      .spr_r      (spr_r),
      .spr_g      (spr_g),
      .spr_b      (spr_b),
      .spr_mask   (spr_mask),
      .o_r        (o_r),
      .o_g        (o_g),
      .o_b        (o_b),
      .sprite_y   (sprite_y),
      .state      (state),
      .dead       (dead)
   );

   // ROM model: registered row, combinational column; opaque at columns 0 and 5.
   logic [10:0] rom_row;
   always @(posedge clk) rom_row <= spr_iy;
   assign spr_mask = (spr_ix == 11'd0) || (spr_ix == 11'd5);
   assign spr_r    = 8'(spr_ix + 11'd64);
   assign spr_g    = 8'(rom_row + 11'd16);
   assign spr_b    = 8'hA5;

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct packed {
      logic [10:0] iy;
      logic [10:0] ix;
      logic [23:0] rgb;
   } exp_t;
   exp_t q[$];

   int         m_y    = 200;
   int         m_vel  = 0;
   logic [1:0] m_st   = S_IDLE;
   bit         m_pend = 1'b0;

   task automatic model_reset();
      m_y = 200; m_vel = 0; m_st = S_IDLE; m_pend = 1'b0;
   endtask

   task automatic pix_step(input int x, input int y);
      exp_t e;
      int   dx, dy, n;
      bit   inwin;
      n = q.size();
      if (n >= 1) begin
         n_chk++;
         if (spr_iy !== q[n-1].iy) $display("FAIL spr_iy: got %0d want %0d", spr_iy, q[n-1].iy);
         else n_pass++;
      end
      if (n >= 2) begin
         n_chk++;
         if (spr_ix !== q[n-2].ix) $display("FAIL spr_ix: got %0d want %0d", spr_ix, q[n-2].ix);
         else n_pass++;
      end
      if (n >= 3) begin
         n_chk++;
         if ({o_r, o_g, o_b} !== q[0].rgb)
            $display("FAIL pix_rgb: got %06h want %06h", {o_r, o_g, o_b}, q[0].rgb);
         else n_pass++;
         void'(q.pop_front());
      end
      dx = x - 100;
      dy = y - m_y;
      inwin = (dx >= 0) && (dx < 26) && (dy >= 0) && (dy < 32);
      e.iy = inwin ? 11'(dy) : 11'd0;
      e.ix = inwin ? 11'(dx) : 11'd0;
      if (inwin && (dx == 0 || dx == 5)) e.rgb = {8'(dx + 64), 8'(dy + 16), 8'hA5};
      else                               e.rgb = {8'(x), 8'(y), 8'h5A};
      i_x = 11'(x); i_y = 11'(y);
      bg_r = 8'(x); bg_g = 8'(y); bg_b = 8'h5A;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic tick(input bit f, input bit h);
      logic signed [11:0] ey;
      int vn, yn;
      frame_tick = 1'b1; flap = f; hit = h;
      @(negedge clk);
      frame_tick = 1'b0; flap = 1'b0; hit = 1'b0;
      case (m_st)
         S_IDLE: if (f) begin m_st = S_RUN; m_vel = -8; m_pend = 1'b0; end
         S_RUN: begin
            if (h) begin
               m_st = S_DEAD; m_pend = 1'b0;
            end else begin
               if (m_pend || f) vn = -8;
               else             vn = (m_vel + 1 > 10) ? 10 : m_vel + 1;
               yn = m_y + vn;
               m_pend = 1'b0;
               if (yn < 0)         begin m_y = 0;   m_vel = 0; end
               else if (yn >= 416) begin m_y = 416; m_vel = 0; m_st = S_DEAD; end
               else                begin m_y = yn;  m_vel = vn; end
            end
         end
         default: m_pend = 1'b0;
      endcase
      ey = 12'(m_y);
      n_chk++;
      if (sprite_y !== ey) $display("FAIL tick_y: got %0d want %0d", sprite_y, ey);
      else n_pass++;
      n_chk++;
      if (state !== m_st) $display("FAIL tick_state: got %b want %b", state, m_st);
      else n_pass++;
   endtask

   task automatic flap_cyc();
      flap = 1'b1;
      @(negedge clk);
      flap = 1'b0;
      if (m_st == S_IDLE) begin m_st = S_RUN; m_vel = -8; m_pend = 1'b0; end
      else if (m_st == S_RUN) m_pend = 1'b1;
      n_chk++;
      if (state !== m_st) $display("FAIL flap_state: got %b want %b", state, m_st);
      else n_pass++;
   endtask

   task automatic restart_cyc();
      logic signed [11:0] ey;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      if (m_st == S_DEAD) begin m_st = S_IDLE; m_y = 200; m_vel = 0; end
      ey = 12'(m_y);
      n_chk++;
      if (state !== m_st) $display("FAIL restart_state: got %b want %b", state, m_st);
      else n_pass++;
      n_chk++;
      if (sprite_y !== ey) $display("FAIL restart_y: got %0d want %0d", sprite_y, ey);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_x = '0; i_y = '0;
      bg_r = 8'h11; bg_g = 8'h22; bg_b = 8'h33;
      frame_tick = 1'b0; flap = 1'b0; hit = 1'b0; restart = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_chk++;
      if (state !== S_IDLE) $display("FAIL rst_state: got %b want %b", state, S_IDLE); else n_pass++;
      n_chk++;
      if (sprite_y !== 12'sd200) $display("FAIL rst_y: got %0d want 200", sprite_y); else n_pass++;
      n_chk++;
      if (dead !== 1'b0) $display("FAIL rst_dead: got %b want 0", dead); else n_pass++;
      n_chk++;
      if ({spr_ix, spr_iy} !== 22'd0) $display("FAIL rst_addr: got %0d/%0d want 0/0", spr_ix, spr_iy);
      else n_pass++;
      n_chk++;
      if ({o_r, o_g, o_b} !== 24'd0) $display("FAIL rst_rgb: got %06h want 000000", {o_r, o_g, o_b});
      else n_pass++;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_chk++;
         if ({o_r, o_g, o_b} !== ((k == 3) ? 24'h112233 : 24'h000000))
            $display("FAIL rst_fill%0d: got %06h want %06h", k, {o_r, o_g, o_b},
                     (k == 3) ? 24'h112233 : 24'h000000);
         else n_pass++;
      end
   endtask

   task automatic test_pixel_scan();
      q.delete();
      for (int x = 96; x <= 130; x++) pix_step(x, 200);
      for (int x = 98; x <= 106; x++) pix_step(x, 199);
      for (int x = 98; x <= 106; x++) pix_step(x, 231);
      for (int x = 103; x <= 106; x++) pix_step(x, 232);
      repeat (3) pix_step(0, 0);
      q.delete();
   endtask

   task automatic test_flap_run();
      int exp3 [3];
      exp3 = '{192, 185, 179};
      flap_cyc();
      flap_cyc();
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0);
         n_chk++;
         if (sprite_y !== 12'(exp3[k])) $display("FAIL run_y%0d: got %0d want %0d", k, sprite_y, exp3[k]);
         else n_pass++;
      end
      flap_cyc();
      tick(1'b0, 1'b0);
   endtask

   task automatic test_floor();
      for (int i = 0; i < 80 && m_st == S_RUN; i++) tick(1'b0, 1'b0);
      n_chk++;
      if (state !== S_DEAD) $display("FAIL floor_state: got %b want %b", state, S_DEAD); else n_pass++;
      n_chk++;
      if (sprite_y !== 12'sd416) $display("FAIL floor_y: got %0d want 416", sprite_y); else n_pass++;
      n_chk++;
      if (dead !== 1'b1) $display("FAIL floor_dead: got %b want 1", dead); else n_pass++;
      flap_cyc();
      tick(1'b1, 1'b0);
      restart_cyc();
   endtask

   task automatic test_ceiling();
      flap_cyc();
      flap_cyc();
      repeat (24) tick(1'b1, 1'b0);
      n_chk++;
      if (sprite_y !== 12'sd8) $display("FAIL ceil_pre: got %0d want 8", sprite_y); else n_pass++;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n_chk++;
      if (sprite_y !== 12'sd0) $display("FAIL ceil_clamp: got %0d want 0", sprite_y); else n_pass++;
      tick(1'b0, 1'b0);
      n_chk++;
      if (sprite_y !== 12'sd1) $display("FAIL ceil_vel0: got %0d want 1", sprite_y); else n_pass++;
   endtask

   task automatic test_hit();
      restart_cyc();
      tick(1'b0, 1'b1);
      n_chk++;
      if (dead !== 1'b1) $display("FAIL hit_tick_dead: got %b want 1", dead); else n_pass++;
      restart_cyc();
      flap_cyc();
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      m_st = S_DEAD; m_pend = 1'b0;
      n_chk++;
      if (state !== S_DEAD) $display("FAIL hit_state: got %b want %b", state, S_DEAD); else n_pass++;
      n_chk++;
      if (sprite_y !== 12'sd200) $display("FAIL hit_y: got %0d want 200", sprite_y); else n_pass++;
      restart_cyc();
   endtask

   task automatic test_mid_reset();
      flap_cyc();
      tick(1'b0, 1'b0);
      i_x = '0; i_y = '0;
      bg_r = 8'hAA; bg_g = 8'hBB; bg_b = 8'hCC;
      repeat (4) @(negedge clk);
      n_chk++;
      if ({o_r, o_g, o_b} !== 24'hAABBCC) $display("FAIL mid_pre: got %06h want aabbcc", {o_r, o_g, o_b});
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (state !== S_IDLE) $display("FAIL mid_state: got %b want %b", state, S_IDLE); else n_pass++;
      n_chk++;
      if (sprite_y !== 12'sd200) $display("FAIL mid_y: got %0d want 200", sprite_y); else n_pass++;
      n_chk++;
      if ({o_r, o_g, o_b} !== 24'd0) $display("FAIL mid_rgb: got %06h want 000000", {o_r, o_g, o_b});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_chk++;
         if ({o_r, o_g, o_b} !== ((k == 3) ? 24'hAABBCC : 24'h000000))
            $display("FAIL mid_fill%0d: got %06h want %06h", k, {o_r, o_g, o_b},
                     (k == 3) ? 24'hAABBCC : 24'h000000);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_pixel_scan();
      test_flap_run();
      test_floor();
      test_ceiling();
      test_hit();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
